// File: rtl/vx_vec_commit_gather.sv
// Splits commit beats into a registered scalar path (latency 1) and a vector gather path that assembles chunk beats into one writeback (last beat -> vec_valid next cycle).
// Backpressure: scalar beats stall only on a full scalar register; vector beats stall only while an assembled op waits for vec_ready.

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_vec_commit_gather #(
  parameter int NUM_LANES  = `NUM_THREADS,
  parameter int NUM_CHUNKS = 4,
  parameter int PID_WIDTH  = `LOG2UP(`NUM_THREADS / NUM_LANES),
  localparam int CHUNK_BITS = `LOG2UP(NUM_CHUNKS),
  localparam int LANE_BITS  = NUM_LANES * `XLEN,
  localparam int DATA_W     = `UUID_WIDTH + `NW_WIDTH + NUM_LANES + `XLEN + 1 + `NR_BITS
                              + LANE_BITS + PID_WIDTH + 3 + `NR_BITS + CHUNK_BITS + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              sc_valid,
  output logic [DATA_W-1:0]                 sc_data,
  input  logic                              sc_ready,
  output logic                              vec_valid,
  output logic [`UUID_WIDTH-1:0]            vec_uuid,
  output logic [`NW_WIDTH-1:0]              vec_wid,
  output logic [`NR_BITS-1:0]               vec_vd,
  output logic [NUM_CHUNKS*LANE_BITS-1:0]   vec_data,
  output logic [NUM_CHUNKS*NUM_LANES-1:0]   vec_tmask,
  output logic [NUM_CHUNKS-1:0]             vec_chunk_mask,
  input  logic                              vec_ready,
  output logic                              err
);

  typedef struct packed {
    logic [`UUID_WIDTH-1:0] uuid;
    logic [`NW_WIDTH-1:0]   wid;
    logic [NUM_LANES-1:0]   tmask;
    logic [`XLEN-1:0]       pc;
    logic                   wb;
    logic [`NR_BITS-1:0]    rd;
    logic [LANE_BITS-1:0]   data;
    logic [PID_WIDTH-1:0]   pid;
    logic                   sop;
    logic                   eop;
    logic                   is_vec;
    logic [`NR_BITS-1:0]    vd;
    logic [CHUNK_BITS-1:0]  vd_lane_id;
    logic                   vd_is_last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  beat_t  in_beat;
  state_t state_q, state_d;

  logic                   sc_vld_q;
  logic [DATA_W-1:0]      sc_dat_q;
  logic                   scalar_rdy;
  logic                   sc_fire;
  logic                   vec_fire;

  logic [NUM_CHUNKS-1:0]  lane_onehot;
  logic                   lane_ok;
  logic                   id_match;
  logic                   dup_chunk;

  logic                   buf_wr;
  logic                   buf_clr;
  logic                   id_ld;
  logic                   err_d;
  logic                   err_q;

  logic [`UUID_WIDTH-1:0] uuid_q;
  logic [`NW_WIDTH-1:0]   wid_q;
  logic [`NR_BITS-1:0]    vd_q;
  logic [NUM_CHUNKS-1:0]  chunk_mask_q;
  logic [LANE_BITS-1:0]   data_buf  [NUM_CHUNKS];
  logic [NUM_LANES-1:0]   tmask_buf [NUM_CHUNKS];

  logic unused_fields;

  assign in_beat = beat_t'(in_data);
  assign unused_fields = ^{in_beat.pc, in_beat.wb, in_beat.rd, in_beat.pid,
                           in_beat.sop, in_beat.eop};

  // Holding reset low also holds in_ready low so nothing is accepted during reset.
  assign scalar_rdy = !sc_vld_q || sc_ready;
  assign in_ready   = reset && (in_beat.is_vec ? (state_q != EMIT) : scalar_rdy);
  assign sc_fire    = in_valid && in_ready && !in_beat.is_vec;
  assign vec_fire   = in_valid && in_ready && in_beat.is_vec;

  // An out-of-range lane id (non power-of-2 chunk count) decodes to no chunk at all.
  always_comb begin
    lane_onehot = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      lane_onehot[k] = (in_beat.vd_lane_id == CHUNK_BITS'(k));
    end
  end

  assign lane_ok   = |lane_onehot;
  assign id_match  = (in_beat.wid == wid_q) && (in_beat.vd == vd_q);
  assign dup_chunk = |(lane_onehot & chunk_mask_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    id_ld   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (vec_fire) begin
          if (!lane_ok) begin
            err_d = 1'b1;
          end else begin
            id_ld   = 1'b1;
            buf_wr  = 1'b1;
            state_d = in_beat.vd_is_last ? EMIT : ACCUM;
          end
        end
      end
      ACCUM: begin
        if (vec_fire) begin
          if (!lane_ok || !id_match) begin
            err_d = 1'b1;
          end else begin
            buf_wr = 1'b1;
            err_d  = dup_chunk;
            if (in_beat.vd_is_last) begin
              state_d = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (vec_ready) begin
          buf_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_vld_q <= 1'b0;
      sc_dat_q <= '0;
    end else if (sc_fire) begin
      sc_vld_q <= 1'b1;
      sc_dat_q <= in_data;
    end else if (sc_ready) begin
      sc_vld_q <= 1'b0;
    end
  end

  // Clearing the buffer on hand-off guarantees chunks missing from the next op read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q        <= 1'b0;
      uuid_q       <= '0;
      wid_q        <= '0;
      vd_q         <= '0;
      chunk_mask_q <= '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        data_buf[k]  <= '0;
        tmask_buf[k] <= '0;
      end
    end else begin
      err_q <= err_d;
      if (id_ld) begin
        uuid_q <= in_beat.uuid;
        wid_q  <= in_beat.wid;
        vd_q   <= in_beat.vd;
      end
      if (buf_clr) begin
        chunk_mask_q <= '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          data_buf[k]  <= '0;
          tmask_buf[k] <= '0;
        end
      end else if (buf_wr) begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (lane_onehot[k]) begin
            data_buf[k]     <= in_beat.data;
            tmask_buf[k]    <= in_beat.tmask;
            chunk_mask_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_pack
    assign vec_data[k*LANE_BITS +: LANE_BITS]  = data_buf[k];
    assign vec_tmask[k*NUM_LANES +: NUM_LANES] = tmask_buf[k];
  end

  assign sc_valid       = sc_vld_q;
  assign sc_data        = sc_dat_q;
  assign vec_valid      = (state_q == EMIT);
  assign vec_uuid       = uuid_q;
  assign vec_wid        = wid_q;
  assign vec_vd         = vd_q;
  assign vec_chunk_mask = chunk_mask_q;
  assign err            = err_q;

endmodule

// File: doc/vx_vec_commit_gather.md
VX_VEC_COMMIT_GATHER -- requirements
Module: VX_vec_commit_gather

Interface
REQ-001 SHALL have parameter NUM_LANES, default `NUM_THREADS: lanes per commit beat.
REQ-002 SHALL have parameter NUM_CHUNKS, default 4: beats per full vector register; CHUNK_BITS = `LOG2UP(NUM_CHUNKS); vd_lane_id width equals CHUNK_BITS.
REQ-003 SHALL have parameter PID_WIDTH, default `LOG2UP(`NUM_THREADS / NUM_LANES): pid field width.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, all state rising-edge.
REQ-006 reset  input  1  asynchronous, active-low (asserted at 0).
REQ-007 in_valid  input  1  commit beat valid.
REQ-008 in_data  input  DATA_W  commit beat, fields uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, is_vec, vd, vd_lane_id, vd_is_last.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 sc_valid / sc_data / sc_ready  output / output DATA_W / input  registered scalar commit output, in_data layout.
REQ-011 vec_valid  output  1  assembled vector writeback valid.
REQ-012 vec_uuid / vec_wid / vec_vd  output  `UUID_WIDTH / `NW_WIDTH / `NR_BITS  identity of assembled op.
REQ-013 vec_data  output  NUM_CHUNKS*NUM_LANES*`XLEN  chunk k at bits [k*NUM_LANES*XLEN +: NUM_LANES*XLEN].
REQ-014 vec_tmask  output  NUM_CHUNKS*NUM_LANES  per-element mask, same chunk ordering.
REQ-015 vec_chunk_mask  output  NUM_CHUNKS  chunks received.
REQ-016 vec_ready  input  1  vector consumer accepts.
REQ-017 err  output  1  one-cycle pulse on protocol violation.

Function
REQ-018 Routing: is_vec=0 beats go to scalar path; is_vec=1 beats go to gather path.
REQ-019 Scalar path: 1-entry register; accept when !sc_valid || sc_ready; accepted beat appears on sc_data with sc_valid the next cycle (latency 1); back-to-back throughput 1 beat/cycle with sc_ready=1.
REQ-020 Gather FSM states IDLE, ACCUM, EMIT.
REQ-021 IDLE: vector beat accepted; latch uuid, wid, vd; write data/tmask into chunk vd_lane_id; set chunk_mask bit; go EMIT if vd_is_last else ACCUM.
REQ-022 ACCUM: beat with matching wid and vd written into chunk vd_lane_id; vd_is_last -> EMIT, else stay.
REQ-023 ACCUM, mismatched wid or vd: beat accepted and dropped, err pulses, state and buffer unchanged.
REQ-024 ACCUM, chunk bit already set: data overwritten, err pulses.
REQ-025 EMIT: vec_valid=1, outputs stable while vec_ready=0; vector beats not accepted (in_ready=0 for is_vec=1); on vec_ready -> IDLE, chunk_mask cleared same edge.
REQ-026 in_ready = scalar-path-ready when is_vec=0, (state != EMIT) when is_vec=1; scalar and vector paths SHALL not block each other.
REQ-027 Latency: vd_is_last beat accepted at cycle N -> vec_valid at N+1.
REQ-028 Single-chunk op (first beat has vd_is_last) SHALL go IDLE -> EMIT with only that chunk bit set.
REQ-029 Missing chunks SHALL not stall emission; their data bits hold 0 and chunk_mask bit 0.
REQ-030 vd_lane_id >= NUM_CHUNKS (non-power-of-2 NUM_CHUNKS): beat dropped, err pulses.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, sc_valid=0, vec_valid=0, err=0, chunk_mask=0, vec_data=0, vec_tmask=0, in_ready=0.
REQ-032 Reset mid-ACCUM or mid-EMIT SHALL discard the partial/pending op; no vec_valid after release until a new op completes.
REQ-033 First beat SHALL be accepted on the first rising edge after reset returns to 1.

Verification
REQ-034 NUM_LANES=4, NUM_CHUNKS=4: beats wid=1, vd=5, lane_id 0..3, data 0x10+k, last on 3, vec_ready=1 -> vec_valid one cycle after beat 3, chunk_mask=4'b1111, chunk k data=0x10+k.
REQ-035 Scalar beat rd=7 interleaved between vector beats 1 and 2 -> sc_valid next cycle with rd=7; vector op still completes with chunk_mask=4'b1111.
REQ-036 In ACCUM for wid=1/vd=5, beat wid=2 -> err=1 one cycle, chunk_mask unchanged, later matching last beat emits correctly.
REQ-037 EMIT with vec_ready=0 for 5 cycles, new vector beat presented -> in_ready=0, vec_data stable; vec_ready=1 -> IDLE, new beat accepted next cycle.
REQ-038 reset=0 during ACCUM after 2 beats -> outputs zero immediately; after release, single beat lane_id=2 with last -> chunk_mask=4'b0100.
REQ-039 sc_ready=0 with sc_valid=1 -> scalar in_ready=0, sc_data held; vector beats still accepted.
